axis_uart_reg_bridge: RTL

Command responder that sits between axis_uart_rx (s_axis) and axis_uart_tx (m_axis). It decodes byte frames sent by a host over UART into register-bus reads and writes, then returns an acknowledge or read data as bytes. Register width, bus timeout and inter-byte timeout are set by parameters.

---
 rtl/axis_uart_reg_bridge.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/axis_uart_reg_bridge.sv
// UART byte-frame to register-bus bridge: decodes write/read frames from s_axis,
// performs one bus access, and returns ACK/NAK or little-endian read data on m_axis.
module axis_uart_reg_bridge #(
    parameter int unsigned DATA_BYTES    = 4,
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned FRAME_TIMEOUT = 5_000_000,
    parameter int unsigned BUS_TIMEOUT   = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [7:0]              s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [7:0]              m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [ADDR_W-1:0]       reg_addr_o,
    output logic [8*DATA_BYTES-1:0] reg_wdata_o,
    output logic                    reg_we_o,
    output logic                    reg_re_o,
    input  logic [8*DATA_BYTES-1:0] reg_rdata_i,
    input  logic                    reg_ack_i
);

    localparam int unsigned DATA_W = 8 * DATA_BYTES;
    localparam int unsigned IDX_W  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int unsigned LEFT_W = $clog2(DATA_BYTES + 1);
    localparam int unsigned FT_W   = $clog2(FRAME_TIMEOUT + 1);
    localparam int unsigned BT_W   = $clog2(BUS_TIMEOUT + 1);

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_BUS,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic                is_wr_q, is_wr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [FT_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic [BT_W-1:0]     bus_cnt_q, bus_cnt_d;
    logic [DATA_W-1:0]   resp_q, resp_d;
    logic [LEFT_W-1:0]   left_q, left_d;
    logic                s_tready_q, s_tready_d;
    logic                m_tvalid_q, m_tvalid_d;
    logic [7:0]          m_tdata_q, m_tdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                re_q, re_d;

    logic s_fire;
    logic m_fire;

    assign s_fire = s_axis_tvalid & s_tready_q;
    assign m_fire = m_tvalid_q & m_axis_tready;

    assign s_axis_tready = s_tready_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tdata  = m_tdata_q;
    assign reg_addr_o    = addr_q;
    assign reg_wdata_o   = wdata_q;
    assign reg_we_o      = we_q;
    assign reg_re_o      = re_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        bus_cnt_d   = bus_cnt_q;
        resp_d      = resp_q;
        left_d      = left_q;
        m_tvalid_d  = m_tvalid_q;
        m_tdata_d   = m_tdata_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (s_fire) begin
                    frame_cnt_d = '0;
                    if (s_axis_tdata == CMD_WR) begin
                        state_d = S_ADDR;
                        is_wr_d = 1'b1;
                    end else if (s_axis_tdata == CMD_RD) begin
                        state_d = S_ADDR;
                        is_wr_d = 1'b0;
                    end else begin
                        state_d    = S_RESP;
                        m_tvalid_d = 1'b1;
                        m_tdata_d  = RSP_NAK;
                        left_d     = LEFT_W'(1);
                    end
                end
            end
            S_ADDR: begin
                if (s_fire) begin
                    addr_d      = ADDR_W'(s_axis_tdata);
                    frame_cnt_d = '0;
                    idx_d       = '0;
                    bus_cnt_d   = '0;
                    state_d     = is_wr_q ? S_WDATA : S_BUS;
                end else if (frame_cnt_q == FT_W'(FRAME_TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    frame_cnt_d = frame_cnt_q + FT_W'(1);
                end
            end
            S_WDATA: begin
                if (s_fire) begin
                    for (int k = 0; k < int'(DATA_BYTES); k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            wdata_d[8*k +: 8] = s_axis_tdata;
                        end
                    end
                    frame_cnt_d = '0;
                    if (idx_q == IDX_W'(DATA_BYTES - 1)) begin
                        state_d   = S_BUS;
                        bus_cnt_d = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (frame_cnt_q == FT_W'(FRAME_TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    frame_cnt_d = frame_cnt_q + FT_W'(1);
                end
            end
            S_BUS: begin
                if (reg_ack_i) begin
                    state_d    = S_RESP;
                    m_tvalid_d = 1'b1;
                    if (is_wr_q) begin
                        m_tdata_d = RSP_ACK;
                        left_d    = LEFT_W'(1);
                    end else begin
                        m_tdata_d = reg_rdata_i[7:0];
                        resp_d    = reg_rdata_i >> 8;
                        left_d    = LEFT_W'(DATA_BYTES);
                    end
                end else if (bus_cnt_q == BT_W'(BUS_TIMEOUT - 1)) begin
                    state_d    = S_RESP;
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = RSP_NAK;
                    left_d     = LEFT_W'(1);
                end else begin
                    bus_cnt_d = bus_cnt_q + BT_W'(1);
                end
            end
            S_RESP: begin
                if (m_fire) begin
                    if (left_q == LEFT_W'(1)) begin
                        state_d    = S_IDLE;
                        m_tvalid_d = 1'b0;
                        m_tdata_d  = '0;
                    end else begin
                        m_tdata_d = resp_q[7:0];
                        resp_d    = resp_q >> 8;
                        left_d    = left_q - LEFT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Ready and strobes follow the state being entered so they line up with it
        s_tready_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_WDATA);
        we_d       = (state_d == S_BUS) && is_wr_d;
        re_d       = (state_d == S_BUS) && !is_wr_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            is_wr_q     <= 1'b0;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            bus_cnt_q   <= '0;
            resp_q      <= '0;
            left_q      <= '0;
            s_tready_q  <= 1'b0;
            m_tvalid_q  <= 1'b0;
            m_tdata_q   <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            bus_cnt_q   <= bus_cnt_d;
            resp_q      <= resp_d;
            left_q      <= left_d;
            s_tready_q  <= s_tready_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tdata_q   <= m_tdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            re_q        <= re_d;
        end
    end

endmodule
